des_f_pipe: RTL
===============

// Module: des_f_pipe
// PURPOSE
//  Pipelined DES round function f(R,K) = P(S(E(R) ^ K)) with valid/ready handshake.
//  Successor to the combinational expansion box: expansion, subkey mix, 8 S-boxes and P permutation,
//  split into PIPE_STAGES register stages with backpressure. Sits between the key schedule and
//  the Feistel round datapath.
//  Bit numbering: DES table bit n maps to vector index n-1 (LSB = DES bit 1) on every bus.
// PARAMETERS
//  PIPE_STAGES  3  register stages, legal 1..3
//                  1: E/XOR/S/P in one stage
//                  2: E/XOR | S/P
//                  3: E/XOR | S | P
//  OCC_W        2  width of occupancy count, must hold PIPE_STAGES
// PORTS
//  clk        in   1   single clock, all state on rising edge
//  rst        in   1   synchronous, active-high reset
//  in_valid   in   1   r_half/subkey valid
//  in_ready   out  1   stage 1 can accept this cycle
//  r_half     in   32  right half R, DES bit n at index n-1
//  subkey     in   48  round subkey K, DES bit n at index n-1
//  out_valid  out  1   f_out valid
//  out_ready  in   1   consumer accepts f_out
//  f_out      out  32  f(R,K), DES bit n at index n-1
//  occupancy  out  OCC_W  number of valid stages in flight
// BEHAVIOUR
//  - Reset: all stage valids = 0, out_valid = 0, f_out = 0, occupancy = 0, in_ready = 1 in the cycle after rst.
//  - Stage k holds valid_k plus its data. Last stage drives out_valid/f_out directly from registers.
//  - Advance rule:
//      adv_last = out_ready | ~valid_last
//      adv_k    = adv_{k+1} | ~valid_k   (bubbles collapse)
//      in_ready = adv_1 (combinational from out_ready, no combinational path from in_valid)
//  - Transfer: input on in_valid & in_ready; output on out_valid & out_ready.
//  - Latency: PIPE_STAGES cycles accept->out_valid with out_ready held 1. Throughput 1/cycle.
//  - Stall: data and valid of a stalled stage hold bit-exact. f_out is stable while out_valid & ~out_ready.
//  - E: standard 32->48 E table.
//      e[6j+5:6j] = {R[4j+4],R[4j+3],R[4j+2],R[4j+1],R[4j],R[4j-1]}, indices mod 32.
//      Wrap: e[0] = R[31], e[47] = R[0].
//  - Mix: x = e ^ subkey.
//  - S-box j (0..7) uses g = x[6j+5:6j].
//      row = {g[0],g[5]}, col = {g[1],g[2],g[3],g[4]}, first-named bit is MSB.
//      4-bit result v placed as s[4j+k] = v[3-k].
//  - P: standard 32-bit P table, out[i] = s[P[i+1]-1].
//  - Simultaneous accept and emit while full: legal, occupancy unchanged.
//  - Occupancy: +1 on accept only, -1 on emit only.
//  - rst mid-operation: in-flight data discarded, no out_valid pulse follows; inputs during rst are ignored.
//  - Data registers need no reset except f_out, but valids always reset.
// STRUCTURE
//  - des_pkg: E_TABLE[48], P_TABLE[32], SBOX[8][64] constants; function des_rev32 for benches.
//  - Sub-module des_sbox_bank: combinational 48->32 lookup of all 8 S-boxes from des_pkg.SBOX.
//  - Pipeline split is generate-selected on PIPE_STAGES.
// TESTING (reference model: des_pkg tables in the bench; rev() = 32/48-bit DES-numbered-to-index mapping)
//  1. R = rev(32'hF0AAF0AA), K = rev(48'h1B02EFFC7072), out_ready = 1
//     -> after PIPE_STAGES cycles f_out = rev(32'h234AA9BB), out_valid 1 cycle.
//  2. 100 random back-to-back inputs, out_ready = 1
//     -> 100 outputs in order, match model, no bubbles, in_ready stays 1.
//  3. Fill pipe, hold out_ready = 0 for 5 cycles
//     -> in_ready = 0 once occupancy = PIPE_STAGES, f_out stable, nothing lost or duplicated on release.
//  4. Random out_ready (50%) with random in_valid
//     -> scoreboard exact order, occupancy always equals model count.
//  5. Assert rst with 2 items in flight
//     -> next cycle out_valid = 0, occupancy = 0, f_out = 0, first post-reset input emerges alone.
//  6. Rerun 1-4 with PIPE_STAGES = 1 and 2 -> identical data, latency = PIPE_STAGES.

Source files
------------

// File: rtl/des_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// des_pkg : DES round-function tables (E, P, S-boxes) and bit-order helpers
// Revision: 1.0
// ---------------------------------------------------------------------------
package des_pkg;

  // Entries are 1-based DES bit numbers; entry i describes output bit i+1.
  localparam int E_TABLE [48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1
  };

  localparam int P_TABLE [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  // SBOX[j][row*16 + col]
  localparam int SBOX [8][64] = '{
    '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
       0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
       4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
      15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
    '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
       3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
       0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
      13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
    '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
      13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
      13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
       1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
    '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
      13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
      10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
       3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
    '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
      14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
       4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
      11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
    '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
      10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
       9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
       4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
    '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
      13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
       1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
       6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
    '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
       1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
       7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
       2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
  };

  // Converts a DES-numbered hex word (bit 1 = MSB) to bus order (bit 1 = index 0).
  function automatic logic [31:0] des_rev32(input logic [31:0] v);
    return {<<{v}};
  endfunction

  function automatic logic [47:0] des_rev48(input logic [47:0] v);
    return {<<{v}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/des_f_pipe_sbox_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// des_sbox_bank : combinational 48->32 lookup through all eight DES S-boxes
// Revision: 1.0
// ---------------------------------------------------------------------------
module des_sbox_bank
  import des_pkg::*;
(
  input  logic [47:0] x,
  output logic [31:0] s
);

  genvar j;
  for (j = 0; j < 8; j++) begin : g_box
    logic [5:0] g;
    logic [3:0] v;
    assign g = x[6*j +: 6];
    // Row comes from the outer bits, column from the inner four.
    assign v = 4'(SBOX[j][{g[0], g[5], g[1], g[2], g[3], g[4]}]);
    assign s[4*j +: 4] = {v[0], v[1], v[2], v[3]};
  end

endmodule
`default_nettype wire

// File: rtl/des_f_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// des_f_pipe : pipelined DES round function f(R,K) = P(S(E(R) ^ K))
// Revision: 1.0
// ---------------------------------------------------------------------------
module des_f_pipe
  import des_pkg::*;
#(
  parameter int PIPE_STAGES = 3,
  parameter int OCC_W       = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      r_half,
  input  logic [47:0]      subkey,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      f_out,
  output logic [OCC_W-1:0] occupancy
);

  localparam int LAST = PIPE_STAGES - 1;

  logic [PIPE_STAGES-1:0] valid_q, valid_d;
  logic [PIPE_STAGES-1:0] adv, vin, load;
  logic [OCC_W-1:0]       occ_q, occ_d;
  logic [31:0]            f_q, f_d;
  logic [47:0]            mix, sbox_in;
  logic [31:0]            sbox_out, perm_in, perm_out;
  logic                   accept, emit;

  genvar i;
  for (i = 0; i < 48; i++) begin : g_expand
    assign mix[i] = r_half[E_TABLE[i] - 1] ^ subkey[i];
  end

  for (i = 0; i < 32; i++) begin : g_perm
    assign perm_out[i] = perm_in[P_TABLE[i] - 1];
  end

  des_sbox_bank u_sbox (
    .x (sbox_in),
    .s (sbox_out)
  );

  // Stage boundaries: E/XOR | S | P, collapsing from the right as depth shrinks.
  if (PIPE_STAGES == 1) begin : g_one
    assign sbox_in = mix;
    assign perm_in = sbox_out;
  end else if (PIPE_STAGES == 2) begin : g_two
    logic [47:0] x_q, x_d;
    always_comb x_d = load[0] ? mix : x_q;
    always_ff @(posedge clk) x_q <= x_d;
    assign sbox_in = x_q;
    assign perm_in = sbox_out;
  end else begin : g_three
    logic [47:0] x_q, x_d;
    logic [31:0] s_q, s_d;
    always_comb begin
      x_d = load[0] ? mix : x_q;
      s_d = load[1] ? sbox_out : s_q;
    end
    always_ff @(posedge clk) begin
      x_q <= x_d;
      s_q <= s_d;
    end
    assign sbox_in = x_q;
    assign perm_in = s_q;
  end

  always_comb begin : ctrl
    logic a;
    adv = '0;
    vin = '0;
    // A stage may move if anything downstream has room, so bubbles collapse.
    a         = out_ready | ~valid_q[LAST];
    adv[LAST] = a;
    for (int k = LAST - 1; k >= 0; k--) begin
      a      = a | ~valid_q[k];
      adv[k] = a;
    end
    vin[0] = in_valid;
    for (int k = 1; k < PIPE_STAGES; k++) begin
      vin[k] = valid_q[k-1];
    end
    load    = adv & vin;
    valid_d = valid_q;
    for (int k = 0; k < PIPE_STAGES; k++) begin
      if (adv[k]) valid_d[k] = vin[k];
    end
    accept = in_valid & adv[0];
    emit   = valid_q[LAST] & out_ready;
    occ_d  = occ_q + OCC_W'(accept) - OCC_W'(emit);
    f_d    = load[LAST] ? perm_out : f_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      occ_q   <= '0;
      f_q     <= '0;
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      f_q     <= f_d;
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = valid_q[LAST];
  assign f_out     = f_q;
  assign occupancy = occ_q;

endmodule
`default_nettype wire
